// File: rtl/sprite_window_array_if.sv
// Pixel-position, shadow-register write and result signals shared between the
// VGA side, the register writer and the sprite window array.
interface sprite_window_array_if #(
   parameter int LAYER_W = 3
);
   logic [9:0]         DrawX;
   logic [9:0]         DrawY;
   logic               frame_start;
   logic               wr_en;
   logic [LAYER_W-1:0] wr_layer;
   logic [2:0]         wr_sel;
   logic [9:0]         wr_data;
   logic               is_sprite;
   logic [LAYER_W-1:0] sprite_layer;
   logic [9:0]         Sprite_X_Addr;
   logic [9:0]         Sprite_Y_Addr;
   logic [3:0]         anim_frame;
   logic               commit_pending;

   modport master (
      output DrawX, DrawY, frame_start, wr_en, wr_layer, wr_sel, wr_data,
      input  is_sprite, sprite_layer, Sprite_X_Addr, Sprite_Y_Addr, anim_frame, commit_pending
   );

   modport slave (
      input  DrawX, DrawY, frame_start, wr_en, wr_layer, wr_sel, wr_data,
      output is_sprite, sprite_layer, Sprite_X_Addr, Sprite_Y_Addr, anim_frame, commit_pending
   );
endinterface

// File: rtl/sprite_window_array.sv
// NUM_LAYERS programmable sprite windows with shadow registers committed at frame
// start, priority hit resolution, registered ROM addresses and a global animation index.
module sprite_window_array #(
   parameter int         NUM_LAYERS  = 4,
   parameter int         LAYER_W     = 3,
   parameter int         ANIM_FRAMES = 4,
   parameter int         ANIM_DIV    = 8,
   parameter logic [9:0] L0_X_POS    = 10'd28,
   parameter logic [9:0] L0_Y_POS    = 10'd80,
   parameter logic [9:0] L0_X_SIZE   = 10'd583,
   parameter logic [9:0] L0_Y_SIZE   = 10'd162
) (
   input logic                   Clk,
   input logic                   Reset,
   sprite_window_array_if.slave  bus
);

   logic [9:0]  sh_x_pos  [NUM_LAYERS];
   logic [9:0]  sh_y_pos  [NUM_LAYERS];
   logic [9:0]  sh_x_size [NUM_LAYERS];
   logic [9:0]  sh_y_size [NUM_LAYERS];
   logic        sh_en     [NUM_LAYERS];

   logic [9:0]  act_x_pos  [NUM_LAYERS];
   logic [9:0]  act_y_pos  [NUM_LAYERS];
   logic [9:0]  act_x_size [NUM_LAYERS];
   logic [9:0]  act_y_size [NUM_LAYERS];
   logic        act_en     [NUM_LAYERS];

   logic [10:0] dx  [NUM_LAYERS];
   logic [10:0] dy  [NUM_LAYERS];
   logic        hit [NUM_LAYERS];

   logic               any_hit;
   logic [LAYER_W-1:0] win_layer;
   logic [9:0]         win_dx;
   logic [9:0]         win_dy;

   logic [7:0]  div_cnt;
   logic [3:0]  anim_cnt;
   logic        pending;
   logic        wr_ok;

   // Out-of-range layers and unused field selects are dropped without touching state.
   assign wr_ok = bus.wr_en && (32'(bus.wr_layer) < NUM_LAYERS) && (bus.wr_sel < 3'd5);

   // Active set is copied from the pre-write shadow, so a same-cycle write waits for the next frame.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_LAYERS; i++) begin
            sh_x_pos[i]   <= (i == 0) ? L0_X_POS  : 10'd0;
            sh_y_pos[i]   <= (i == 0) ? L0_Y_POS  : 10'd0;
            sh_x_size[i]  <= (i == 0) ? L0_X_SIZE : 10'd0;
            sh_y_size[i]  <= (i == 0) ? L0_Y_SIZE : 10'd0;
            sh_en[i]      <= (i == 0);
            act_x_pos[i]  <= (i == 0) ? L0_X_POS  : 10'd0;
            act_y_pos[i]  <= (i == 0) ? L0_Y_POS  : 10'd0;
            act_x_size[i] <= (i == 0) ? L0_X_SIZE : 10'd0;
            act_y_size[i] <= (i == 0) ? L0_Y_SIZE : 10'd0;
            act_en[i]     <= (i == 0);
         end
         pending <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_LAYERS; i++) begin
            if (wr_ok && (bus.wr_layer == LAYER_W'(i))) begin
               case (bus.wr_sel)
                  3'd0:    sh_x_pos[i]  <= bus.wr_data;
                  3'd1:    sh_y_pos[i]  <= bus.wr_data;
                  3'd2:    sh_x_size[i] <= bus.wr_data;
                  3'd3:    sh_y_size[i] <= bus.wr_data;
                  3'd4:    sh_en[i]     <= bus.wr_data[0];
                  default: ;
               endcase
            end
            if (bus.frame_start) begin
               act_x_pos[i]  <= sh_x_pos[i];
               act_y_pos[i]  <= sh_y_pos[i];
               act_x_size[i] <= sh_x_size[i];
               act_y_size[i] <= sh_y_size[i];
               act_en[i]     <= sh_en[i];
            end
         end
         if (wr_ok) begin
            pending <= 1'b1;
         end else if (bus.frame_start) begin
            pending <= 1'b0;
         end
      end
   end

   // The 11-bit difference keeps a sign bit so pixels left of or above a window never alias inside it.
   always_comb begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
         dx[i]  = {1'b0, bus.DrawX} - {1'b0, act_x_pos[i]};
         dy[i]  = {1'b0, bus.DrawY} - {1'b0, act_y_pos[i]};
         hit[i] = act_en[i] & ~dx[i][10] & (dx[i][9:0] < act_x_size[i])
                            & ~dy[i][10] & (dy[i][9:0] < act_y_size[i]);
      end
   end

   // Scanning from the top index down lets the lowest-index hitting layer win.
   always_comb begin
      any_hit   = 1'b0;
      win_layer = '0;
      win_dx    = 10'd0;
      win_dy    = 10'd0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            any_hit   = 1'b1;
            win_layer = LAYER_W'(i);
            win_dx    = dx[i][9:0];
            win_dy    = dy[i][9:0];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         bus.is_sprite     <= 1'b0;
         bus.sprite_layer  <= '0;
         bus.Sprite_X_Addr <= 10'd0;
         bus.Sprite_Y_Addr <= 10'd0;
      end else begin
         bus.is_sprite     <= any_hit;
         bus.sprite_layer  <= win_layer;
         bus.Sprite_X_Addr <= win_dx;
         bus.Sprite_Y_Addr <= win_dy;
      end
   end

   // Animation advances once every ANIM_DIV frames and wraps at ANIM_FRAMES.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         div_cnt  <= 8'd0;
         anim_cnt <= 4'd0;
      end else if (bus.frame_start) begin
         if (div_cnt == 8'(ANIM_DIV - 1)) begin
            div_cnt  <= 8'd0;
            anim_cnt <= (anim_cnt == 4'(ANIM_FRAMES - 1)) ? 4'd0 : anim_cnt + 4'd1;
         end else begin
            div_cnt <= div_cnt + 8'd1;
         end
      end
   end

   assign bus.anim_frame     = anim_cnt;
   assign bus.commit_pending = pending;

endmodule

// File: tb/tb_sprite_window_array.sv
// Table-driven scoreboard bench for sprite_window_array: pixel hits, shadow commit,
// priority, same-cycle write/commit, illegal writes and animation stepping.
module tb_sprite_window_array;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       fs;
      logic       we;
      logic [2:0] wl;
      logic [2:0] ws;
      logic [9:0] wd;
      logic       e_is;
      logic [2:0] e_layer;
      logic [9:0] e_xa;
      logic [9:0] e_ya;
      logic       e_pend;
   } vec_t;

   logic Clk;
   logic Reset;
   int   n_cmp;
   int   n_fail;
   int   vec_idx;
   int   pulse_cnt;
   vec_t vecs [$];
   vec_t sb   [$];

   sprite_window_array_if #(.LAYER_W(3)) bus_if ();

   sprite_window_array #(
      .NUM_LAYERS(4), .LAYER_W(3), .ANIM_FRAMES(4), .ANIM_DIV(8)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus_if)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   function automatic vec_t mk(input int x, input int y, input bit fs, input bit we,
                               input int wl, input int ws, input int wd, input bit e_is,
                               input int e_layer, input int e_xa, input int e_ya, input bit e_pend);
      vec_t v;
      v.x = 10'(x);  v.y = 10'(y);  v.fs = fs;  v.we = we;
      v.wl = 3'(wl); v.ws = 3'(ws); v.wd = 10'(wd);
      v.e_is = e_is; v.e_layer = 3'(e_layer);
      v.e_xa = 10'(e_xa); v.e_ya = 10'(e_ya); v.e_pend = e_pend;
      return v;
   endfunction

   function automatic vec_t px(input int x, input int y, input bit is, input int l,
                               input int xa, input int ya, input bit pend);
      return mk(x, y, 1'b0, 1'b0, 0, 0, 0, is, l, xa, ya, pend);
   endfunction

   function automatic vec_t fsp(input int x, input int y, input bit is, input int l,
                                input int xa, input int ya, input bit pend);
      return mk(x, y, 1'b1, 1'b0, 0, 0, 0, is, l, xa, ya, pend);
   endfunction

   // Writes are issued while pointing at pixel (0,0), which no window in this test covers.
   function automatic vec_t wr(input int l, input int s, input int d, input bit pend);
      return mk(0, 0, 1'b0, 1'b1, l, s, d, 1'b0, 0, 0, 0, pend);
   endfunction

   task automatic check_val(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus_if.DrawX       = 10'd0;
      bus_if.DrawY       = 10'd0;
      bus_if.frame_start = 1'b0;
      bus_if.wr_en       = 1'b0;
      bus_if.wr_layer    = 3'd0;
      bus_if.wr_sel      = 3'd0;
      bus_if.wr_data     = 10'd0;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic apply_stimulus(input vec_t v);
      bus_if.DrawX       = v.x;
      bus_if.DrawY       = v.y;
      bus_if.frame_start = v.fs;
      bus_if.wr_en       = v.we;
      bus_if.wr_layer    = v.wl;
      bus_if.wr_sel      = v.ws;
      bus_if.wr_data     = v.wd;
      sb.push_back(v);
   endtask

   task automatic check_output(input int idx);
      vec_t e;
      if (sb.size() == 0) begin
         check_val($sformatf("v%0d.scoreboard_empty", idx), 0, 1);
         return;
      end
      e = sb.pop_front();
      check_val($sformatf("v%0d.is_sprite", idx),      int'(bus_if.is_sprite),      int'(e.e_is));
      check_val($sformatf("v%0d.sprite_layer", idx),   int'(bus_if.sprite_layer),   int'(e.e_layer));
      check_val($sformatf("v%0d.Sprite_X_Addr", idx),  int'(bus_if.Sprite_X_Addr),  int'(e.e_xa));
      check_val($sformatf("v%0d.Sprite_Y_Addr", idx),  int'(bus_if.Sprite_Y_Addr),  int'(e.e_ya));
      check_val($sformatf("v%0d.commit_pending", idx), int'(bus_if.commit_pending), int'(e.e_pend));
   endtask

   task automatic pulse_frames(input int n);
      for (int k = 0; k < n; k++) begin
         bus_if.frame_start = 1'b1;
         tick();
         pulse_cnt++;
         check_val($sformatf("anim_after_%0d_pulses", pulse_cnt),
                   int'(bus_if.anim_frame), (pulse_cnt / 8) % 4);
      end
      bus_if.frame_start = 1'b0;
   endtask

   initial begin
      n_cmp     = 0;
      n_fail    = 0;
      pulse_cnt = 0;
      Reset     = 1'b1;
      drive_idle();

      // Title sweep and edge exclusivity
      vecs.push_back(px(28, 80, 1, 0, 0, 0, 0));
      vecs.push_back(px(610, 241, 1, 0, 582, 161, 0));
      vecs.push_back(px(611, 80, 0, 0, 0, 0, 0));
      vecs.push_back(px(27, 80, 0, 0, 0, 0, 0));
      vecs.push_back(px(28, 242, 0, 0, 0, 0, 0));
      vecs.push_back(px(28, 241, 1, 0, 0, 161, 0));
      // Disable the title, then stage layer 1 mid-frame
      vecs.push_back(wr(0, 4, 0, 1));
      vecs.push_back(fsp(0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(wr(1, 0, 100, 1));
      vecs.push_back(wr(1, 1, 100, 1));
      vecs.push_back(wr(1, 2, 32, 1));
      vecs.push_back(wr(1, 3, 32, 1));
      vecs.push_back(wr(1, 4, 1, 1));
      vecs.push_back(px(110, 110, 0, 0, 0, 0, 1));
      vecs.push_back(fsp(110, 110, 0, 0, 0, 0, 0));
      vecs.push_back(px(110, 110, 1, 1, 10, 10, 0));
      vecs.push_back(px(131, 131, 1, 1, 31, 31, 0));
      vecs.push_back(px(132, 110, 0, 0, 0, 0, 0));
      // Priority between overlapping layers 0 and 2
      vecs.push_back(wr(0, 0, 100, 1));
      vecs.push_back(wr(0, 1, 100, 1));
      vecs.push_back(wr(0, 2, 50, 1));
      vecs.push_back(wr(0, 3, 50, 1));
      vecs.push_back(wr(0, 4, 1, 1));
      vecs.push_back(wr(2, 0, 120, 1));
      vecs.push_back(wr(2, 1, 120, 1));
      vecs.push_back(wr(2, 2, 50, 1));
      vecs.push_back(wr(2, 3, 50, 1));
      vecs.push_back(wr(2, 4, 1, 1));
      vecs.push_back(fsp(0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(px(130, 130, 1, 0, 30, 30, 0));
      vecs.push_back(px(160, 160, 1, 2, 40, 40, 0));
      vecs.push_back(px(149, 149, 1, 0, 49, 49, 0));
      vecs.push_back(px(150, 150, 1, 2, 30, 30, 0));
      // Write coincident with frame_start waits for the following frame
      vecs.push_back(mk(0, 0, 1'b1, 1'b1, 1, 0, 200, 0, 0, 0, 0, 1));
      vecs.push_back(px(205, 110, 0, 0, 0, 0, 1));
      vecs.push_back(fsp(205, 110, 0, 0, 0, 0, 0));
      vecs.push_back(px(205, 110, 1, 1, 5, 10, 0));
      vecs.push_back(px(110, 110, 1, 0, 10, 10, 0));
      // Illegal layer and field selects are ignored
      vecs.push_back(wr(5, 0, 300, 0));
      vecs.push_back(wr(1, 5, 0, 0));
      vecs.push_back(fsp(205, 110, 1, 1, 5, 10, 0));
      vecs.push_back(px(205, 110, 1, 1, 5, 10, 0));
      // Zero width never hits
      vecs.push_back(wr(3, 0, 300, 1));
      vecs.push_back(wr(3, 1, 300, 1));
      vecs.push_back(wr(3, 2, 0, 1));
      vecs.push_back(wr(3, 3, 10, 1));
      vecs.push_back(wr(3, 4, 1, 1));
      vecs.push_back(fsp(0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(px(300, 300, 0, 0, 0, 0, 0));
      vecs.push_back(px(300, 305, 0, 0, 0, 0, 0));
      // Window near the right edge must not wrap around to small DrawX
      vecs.push_back(wr(3, 0, 1000, 1));
      vecs.push_back(wr(3, 1, 0, 1));
      vecs.push_back(wr(3, 2, 100, 1));
      vecs.push_back(wr(3, 3, 100, 1));
      vecs.push_back(fsp(0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(px(5, 5, 0, 0, 0, 0, 0));
      vecs.push_back(px(1010, 5, 1, 3, 10, 5, 0));
      vecs.push_back(px(999, 5, 0, 0, 0, 0, 0));

      // Reset state while pointing inside the title window
      bus_if.DrawX = 10'd28;
      bus_if.DrawY = 10'd80;
      tick();
      tick();
      check_val("reset.is_sprite",      int'(bus_if.is_sprite),      0);
      check_val("reset.Sprite_X_Addr",  int'(bus_if.Sprite_X_Addr),  0);
      check_val("reset.commit_pending", int'(bus_if.commit_pending), 0);
      check_val("reset.anim_frame",     int'(bus_if.anim_frame),     0);
      Reset = 1'b0;
      drive_idle();
      tick();

      $display("[TB] running %0d table vectors", vecs.size());
      vec_idx = 0;
      foreach (vecs[i]) begin
         apply_stimulus(vecs[i]);
         tick();
         check_output(vec_idx);
         vec_idx++;
      end
      drive_idle();

      // Animation stepping and wrap
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      pulse_cnt = 0;
      check_val("anim.after_reset", int'(bus_if.anim_frame), 0);
      pulse_frames(32);
      check_val("anim.wrapped_32", int'(bus_if.anim_frame), 0);

      // Mid-sequence reset clears divider, animation, pending state and restores the title
      pulse_frames(5);
      bus_if.wr_en    = 1'b1;
      bus_if.wr_layer = 3'd2;
      bus_if.wr_sel   = 3'd0;
      bus_if.wr_data  = 10'd7;
      tick();
      check_val("midreset.pending_before", int'(bus_if.commit_pending), 1);
      drive_idle();
      bus_if.DrawX       = 10'd28;
      bus_if.DrawY       = 10'd80;
      bus_if.frame_start = 1'b1;
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      bus_if.frame_start = 1'b0;
      check_val("midreset.anim_frame",     int'(bus_if.anim_frame),     0);
      check_val("midreset.commit_pending", int'(bus_if.commit_pending), 0);
      check_val("midreset.is_sprite",      int'(bus_if.is_sprite),      0);
      tick();
      check_val("midreset.title_hit",   int'(bus_if.is_sprite),    1);
      check_val("midreset.title_layer", int'(bus_if.sprite_layer), 0);
      pulse_cnt = 0;
      pulse_frames(7);
      check_val("midreset.no_step_7", int'(bus_if.anim_frame), 0);
      pulse_frames(1);
      check_val("midreset.step_8", int'(bus_if.anim_frame), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_window_array.md
Name: sprite_window_array

Overview:
- Parametrised successor to the single fixed-position title window detector.
- Tracks NUM_LAYERS rectangular sprite windows with runtime-programmable position, size and enable. Each window has a shadow register set; shadow values become active only at frame start, which prevents tearing.
- Each cycle it priority-resolves which layer covers the current pixel and outputs the relative ROM address plus a global animation frame index. All outputs are registered with 1-cycle latency.
- Sits between the VGA controller (DrawX/DrawY) and the colour mapper / sprite ROMs.

Parameters:
- NUM_LAYERS, 4, number of sprite windows; layer 0 has highest priority. Range 1..8.
- LAYER_W, 3, width of the layer index output; must satisfy 2^LAYER_W >= NUM_LAYERS.
- ANIM_FRAMES, 4, number of animation frames; the index wraps modulo this value. Range 1..16.
- ANIM_DIV, 8, number of frame_start pulses per animation step. Range 1..255.
- L0_X_POS / L0_Y_POS / L0_X_SIZE / L0_Y_SIZE, 28 / 80 / 583 / 162, reset geometry of layer 0 (the title).

Ports:
- Clk  in  1  pixel/system clock
- Reset  in  1  synchronous, active-high reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- frame_start  in  1  one-cycle pulse at the start of each frame (vsync edge)
- wr_en  in  1  shadow register write strobe
- wr_layer  in  LAYER_W  target layer for the write
- wr_sel  in  3  field select: 0 X_Pos, 1 Y_Pos, 2 X_Size, 3 Y_Size, 4 enable (wr_data[0]); 5..7 ignored
- wr_data  in  10  write data
- is_sprite  out  1  current pixel lies inside an enabled layer
- sprite_layer  out  LAYER_W  index of the winning layer
- Sprite_X_Addr  out  10  DrawX minus the winning layer's X_Pos
- Sprite_Y_Addr  out  10  DrawY minus the winning layer's Y_Pos
- anim_frame  out  4  global animation frame index
- commit_pending  out  1  at least one shadow write has not yet been committed

Behaviour:
- Reset (synchronous, highest priority over all other activity, including mid-frame):
  - Layer 0: shadow and active registers load the L0_* defaults; layer enabled.
  - Layers 1..N-1: all fields 0; layers disabled.
  - All outputs 0; divider and anim_frame 0; commit_pending 0.
- Writes:
  - wr_en=1 updates shadow[wr_layer].field on the rising edge; commit_pending is set.
  - wr_layer >= NUM_LAYERS or wr_sel >= 5: the write is ignored and commit_pending is unchanged.
- Commit:
  - On frame_start=1, all active registers are loaded from the shadow registers and commit_pending is cleared.
  - A write in the same cycle as frame_start lands in the shadow but is NOT part of that commit. commit_pending ends at 1.
- Hit test, per layer i, per cycle:
  - dx = {1'b0,DrawX} - {1'b0,X_Pos}, computed at 11 bits; dy likewise.
  - hit_i = enable_i & ~dx[10] & (dx[9:0] < X_Size) & ~dy[10] & (dy[9:0] < Y_Size).
  - Negative offsets never hit; there is no unsigned wrap-around aliasing. Size 0 never hits.
  - The right and bottom edges are exclusive (X_Pos+X_Size is outside the window).
- Priority: the lowest-index layer with hit_i=1 wins.
- Output register, updated every cycle:
  - If any layer hits: is_sprite=1, sprite_layer=winner, Sprite_X_Addr=dx[9:0], Sprite_Y_Addr=dy[9:0].
  - Otherwise all four outputs are 0.
- Latency: the outputs in cycle n+1 correspond to DrawX/DrawY in cycle n. The hit test in cycle n uses the active registers as they were before any commit in cycle n.
- Animation:
  - The divider increments on each frame_start.
  - At ANIM_DIV-1 plus one more frame_start, the divider wraps to 0 and anim_frame increments.
  - anim_frame wraps from ANIM_FRAMES-1 to 0.
  - With ANIM_DIV=1, anim_frame steps on every frame_start.
- No handshake stalls: the block accepts a write every cycle.

Test Plan:
- Reset, then sweep DrawX/DrawY across the title window:
  - (28,80) -> one cycle later is_sprite=1, layer 0, addr (0,0).
  - (610,241) -> hit, addr (582,161).
  - (611,80) and (27,80) -> is_sprite=0, addr 0.
- Shadow commit:
  - Write layer 1 X=100, Y=100, Xs=32, Ys=32, enable=1 mid-frame.
  - Pixel (110,110) before frame_start -> miss, commit_pending=1.
  - After frame_start -> hit, layer 1, addr (10,10); commit_pending=0.
- Priority:
  - Layer 0 at (100,100) size 50x50 and layer 2 at (120,120) size 50x50.
  - Pixel (130,130) -> layer 0, addr (30,30).
  - Pixel (160,160) -> layer 2, addr (40,40).
- Same-cycle write and frame_start:
  - Write layer 1 X=200 coincident with frame_start -> active X is unchanged and commit_pending=1.
  - At the next frame_start, X=200 becomes active.
- Animation with ANIM_DIV=8, ANIM_FRAMES=4:
  - 8 frame_start pulses -> anim_frame=1.
  - 32 pulses -> anim_frame=0 (wrap).
  - Reset asserted after 5 pulses -> divider and anim_frame are 0, and the next step occurs only after 8 further pulses.
- Illegal and edge writes:
  - wr_layer=5 with NUM_LAYERS=4 -> no state change and commit_pending stays 0.
  - Size 0 -> never hits.
  - X_Pos=1000 with DrawX=5 -> miss (no wrap-around hit).
